// File: rtl/alu_iter_if.sv
// Operand/result handshake bundle for alu_iter: valid/ready on both the request and the response side.
interface alu_iter_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] i_1;
  logic [XLEN-1:0] i_2;
  logic [3:0]      aluSel;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero_flag;

  modport master (
    output in_valid, i_1, i_2, aluSel, out_ready,
    input  in_ready, out_valid, result, zero_flag
  );

  modport slave (
    input  in_valid, i_1, i_2, aluSel, out_ready,
    output in_ready, out_valid, result, zero_flag
  );
endinterface

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arith ops, XLEN-step shift-add multiply and restoring divide.
// Latency 1 for simple ops, XLEN+1 for MUL/MULHU/DIVU/REMU; result held in DONE until out_ready.
module alu_iter #(
  parameter  int XLEN = 32,
  localparam int SHW  = $clog2(XLEN)
) (
  input logic       clk,
  input logic       rst,
  alu_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SHW-1:0] LAST_STEP = SHW'(XLEN - 1);

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            iter_sel;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] quick_res;

  logic            is_div;
  logic            res_hi;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  logic [XLEN-1:0] b_reg;
  logic [SHW-1:0]  cnt;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_sub;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;
  logic [XLEN-1:0] final_res;

  logic [XLEN-1:0] result_r;
  logic            zero_r;

  assign shamt  = bus.i_2[SHW-1:0];
  assign accept = bus.in_valid && (state == IDLE);

  // Division by zero bypasses the iterative path and resolves in one cycle.
  assign iter_sel = (bus.aluSel[3:2] == 2'b11) && !(bus.aluSel[1] && (bus.i_2 == '0));

  always_comb begin
    quick_res = '0;
    unique case (bus.aluSel)
      4'b0000: quick_res = bus.i_1 & bus.i_2;
      4'b0001: quick_res = bus.i_1 | bus.i_2;
      4'b0010: quick_res = bus.i_1 + bus.i_2;
      4'b0011: quick_res = bus.i_1 - bus.i_2;
      4'b0100: quick_res[0] = (bus.i_1 < bus.i_2);
      4'b0101: quick_res = bus.i_2;
      4'b0110: quick_res = bus.i_1 ^ bus.i_2;
      4'b0111: quick_res = (bus.i_2 << 12) + bus.i_1;
      4'b1000: quick_res = bus.i_1 << shamt;
      4'b1001: quick_res = bus.i_1 >> shamt;
      4'b1010: quick_res = $signed(bus.i_1) >>> shamt;
      4'b1011: quick_res[0] = ($signed(bus.i_1) < $signed(bus.i_2));
      4'b1110: quick_res = '1;
      4'b1111: quick_res = bus.i_1;
      default: quick_res = '0;
    endcase
  end

  // hi:lo is the product (multiplier shifts out of lo) or remainder:quotient (dividend shifts out of lo).
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_reg} : '0);
    rem_sh  = {hi, lo[XLEN-1]};
    rem_ge  = (rem_sh >= {1'b0, b_reg});
    rem_sub = rem_sh[XLEN-1:0] - b_reg;
    if (is_div) begin
      step_hi = rem_ge ? rem_sub : rem_sh[XLEN-1:0];
      step_lo = {lo[XLEN-2:0], rem_ge};
    end else begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], lo[XLEN-1:1]};
    end
    final_res = res_hi ? step_hi : step_lo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          state_nxt = iter_sel ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (cnt == LAST_STEP) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      is_div   <= 1'b0;
      res_hi   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      b_reg    <= '0;
      cnt      <= '0;
      result_r <= '0;
      zero_r   <= 1'b1;
    end else if (accept) begin
      is_div <= bus.aluSel[1];
      res_hi <= bus.aluSel[0];
      cnt    <= '0;
      if (iter_sel) begin
        hi    <= '0;
        lo    <= bus.i_1;
        b_reg <= bus.i_2;
      end else begin
        result_r <= quick_res;
        zero_r   <= (quick_res == '0);
      end
    end else if (state == BUSY) begin
      hi  <= step_hi;
      lo  <= step_lo;
      cnt <= cnt + SHW'(1);
      if (cnt == LAST_STEP) begin
        result_r <= final_res;
        zero_r   <= (final_res == '0);
      end
    end
  end

  assign bus.result    = result_r;
  assign bus.zero_flag = zero_r;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: hand-computed vectors plus a per-cycle comparison against a behavioural model.
module tb_alu_iter;
  localparam int XLEN = 32;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  alu_iter_if #(.XLEN(XLEN)) bus ();

  alu_iter #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a - b;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return b;
      4'd6:  return a ^ b;
      4'd7:  return (b << 12) + a;
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return $signed(a) >>> b[4:0];
      4'd11: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd12: return p[31:0];
      4'd13: return p[63:32];
      4'd14: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
    if (op >= 4'd12 && !(op >= 4'd14 && b == 0)) return XLEN + 1;
    return 1;
  endfunction

  // Model: outstanding op becomes visible at cycle ready_at and stays until taken.
  int          cyc;
  bit          m_live;
  bit          m_busy;
  int          m_ready_at;
  logic [31:0] m_pend;
  logic [31:0] m_shown;

  initial begin
    cyc = 0; m_live = 0; m_busy = 0; m_ready_at = 0; m_pend = '0; m_shown = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy  = 0;
        m_shown = '0;
        m_live  = 1;
      end else if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy     = 1;
          m_pend     = model(bus.aluSel, bus.i_1, bus.i_2);
          m_ready_at = cyc + lat_of(bus.aluSel, bus.i_2);
        end
      end else if (cyc >= m_ready_at && bus.out_ready) begin
        m_busy = 0;
      end
      cyc++;
      if (m_busy && cyc == m_ready_at) m_shown = m_pend;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_live) begin
        check("cyc_in_ready", bus.in_ready, !m_busy);
        check("cyc_out_valid", bus.out_valid, m_busy && (cyc >= m_ready_at));
        check("cyc_result", bus.result, m_shown);
        check("cyc_zero_flag", bus.zero_flag, m_shown == 0);
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic zf);
    @(negedge clk);
    bus.i_1 = a; bus.i_2 = b; bus.aluSel = op; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.i_1 = $urandom; bus.i_2 = $urandom; bus.aluSel = 4'($urandom_range(0, 15));
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL out_valid_timeout: got no out_valid required within 200 cycles");
    end
    res = bus.result;
    zf  = bus.zero_flag;
  endtask

  task automatic run_vec(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] r;
    int          l;
    logic        z;
    run_op(op, a, b, r, l, z);
    check({name, "_res"}, r, exp);
    check({name, "_lat"}, l, exp_lat);
    check({name, "_zf"}, z, exp == 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.i_1 = '0; bus.i_2 = '0; bus.aluSel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_result", bus.result, 32'd0);
    check("reset_zero_flag", bus.zero_flag, 1'b1);
    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);

    run_vec("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1);
    @(negedge clk);
    check("add_wrap_in_ready_back", bus.in_ready, 1'b1);

    run_vec("mulhu_max", 4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_vec("mul_max",   4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
    run_vec("divu_100_7", 4'd14, 32'd100, 32'd7, 32'd14, 33);
    run_vec("remu_100_7", 4'd15, 32'd100, 32'd7, 32'd2, 33);
    run_vec("divu_by0",  4'd14, 32'd100, 32'd0, 32'hFFFF_FFFF, 1);
    run_vec("remu_by0",  4'd15, 32'd5, 32'd0, 32'd5, 1);
    run_vec("sra",       4'd10, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1);
    run_vec("slt_neg",   4'd11, 32'hFFFF_FFFF, 32'd0, 32'd1, 1);
    run_vec("sltu_big",  4'd4, 32'hFFFF_FFFF, 32'd0, 32'd0, 1);
    run_vec("and",       4'd0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1);
    run_vec("or",        4'd1, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1);
    run_vec("sub_neg",   4'd3, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run_vec("pass_b",    4'd5, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 1);
    run_vec("xor",       4'd6, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1);
    run_vec("lui_add",   4'd7, 32'h0000_0345, 32'h0000_0012, 32'h0001_2345, 1);
    run_vec("sll_mask",  4'd8, 32'd1, 32'h0000_0021, 32'd2, 1);
    run_vec("srl_31",    4'd9, 32'h8000_0000, 32'd31, 32'd1, 1);
    run_vec("mul_zero",  4'd12, 32'h0001_0000, 32'h0001_0000, 32'd0, 33);
    run_vec("mulhu_one", 4'd13, 32'h0001_0000, 32'h0001_0000, 32'd1, 33);
    run_vec("divu_big",  4'd14, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33);
    run_vec("remu_big",  4'd15, 32'hFFFF_FFFF, 32'h10, 32'hF, 33);
    run_vec("divu_small", 4'd14, 32'd3, 32'd5, 32'd0, 33);
    run_vec("remu_small", 4'd15, 32'd3, 32'd5, 32'd3, 33);

    // Consumer stalls while the producer keeps poking the inputs.
    @(negedge clk);
    bus.i_1 = 32'd7; bus.i_2 = 32'd8; bus.aluSel = 4'd2; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_out_valid", bus.out_valid, 1'b1);
      check("hold_in_ready", bus.in_ready, 1'b0);
      check("hold_result", bus.result, 32'd15);
      bus.i_1 = $urandom; bus.in_valid = ~bus.in_valid;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1'b1);
    check("release_out_valid", bus.out_valid, 1'b0);

    // Reset in the middle of a divide, colliding with a fresh request.
    @(negedge clk);
    bus.i_1 = 32'd100; bus.i_2 = 32'd7; bus.aluSel = 4'd14; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", bus.in_ready, 1'b0);
    rst = 1'b1; bus.in_valid = 1'b1; bus.aluSel = 4'd2; bus.i_1 = 32'd1; bus.i_2 = 32'd1;
    @(negedge clk);
    rst = 1'b0; bus.in_valid = 1'b0;
    check("abort_out_valid", bus.out_valid, 1'b0);
    check("abort_result", bus.result, 32'd0);
    check("abort_zero_flag", bus.zero_flag, 1'b1);
    check("abort_in_ready", bus.in_ready, 1'b1);
    run_vec("add_after_abort", 4'd2, 32'd2, 32'd3, 32'd5, 1);

    // Reset while a result waits in DONE with out_ready asserted.
    @(negedge clk);
    bus.i_1 = 32'd9; bus.i_2 = 32'd9; bus.aluSel = 4'd1; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("done_pending", bus.out_valid, 1'b1);
    rst = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("done_abort_out_valid", bus.out_valid, 1'b0);
    check("done_abort_result", bus.result, 32'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
